// File: rtl/sh7604_sci_rx.sv
// SH7604 SCI asynchronous receiver: 16x-oversampled start/data/parity/stop
// framing, SSR status flags, overrun handling and multiprocessor frame filtering.
module sh7604_sci_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       CE,
   input  logic       BAUD_TICK,
   input  logic       RXD,
   input  logic [7:0] SMR,
   input  logic       RE,
   input  logic       MPIE,
   input  logic       RDRF_CLR,
   input  logic       ORER_CLR,
   input  logic       FER_CLR,
   input  logic       PER_CLR,
   output logic [7:0] RDR,
   output logic       RDRF,
   output logic       ORER,
   output logic       FER,
   output logic       PER,
   output logic       MPB,
   output logic       MPIE_CLR
);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARB, S_STOP} state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   rxd_prev_q, rxd_prev_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [2:0]             bit_idx_q, bit_idx_d;
   logic [7:0]             shreg_q, shreg_d;
   logic                   per_pend_q, per_pend_d;
   logic                   mpb_bit_q, mpb_bit_d;
   logic [7:0]             rdr_q, rdr_d;
   logic                   rdrf_q, rdrf_d;
   logic                   orer_q, orer_d;
   logic                   fer_q, fer_d;
   logic                   per_q, per_d;
   logic                   mpb_q, mpb_d;
   logic                   mpie_clr_q, mpie_clr_d;

   logic       chr, pe, oe, mp;
   logic       rxd_s, sample, err_block;
   logic [7:0] data_w;
   logic       unused_smr;

   assign chr        = SMR[6];
   assign pe         = SMR[5];
   assign oe         = SMR[4];
   assign mp         = SMR[2];
   assign unused_smr = ^{SMR[7], SMR[3], SMR[1:0]};

   assign rxd_s     = sync_q[SYNC_STAGES-1];
   // Mid-bit sample: counter wraps mod 16, so every bit after the start bit is 16 ticks apart.
   assign sample    = BAUD_TICK && (cnt_q == 4'd7);
   assign err_block = orer_q | fer_q | per_q;
   // In 7-bit mode the data sits in the upper seven shift-register bits.
   assign data_w    = chr ? {1'b0, shreg_q[7:1]} : shreg_q;

   always_comb begin
      // NOTE: every signal gets its hold value first so no path through the
      // case/if tree leaves it unassigned, which would infer a latch.
      state_d    = state_q;
      sync_d     = sync_q;
      rxd_prev_d = rxd_prev_q;
      cnt_d      = cnt_q;
      bit_idx_d  = bit_idx_q;
      shreg_d    = shreg_q;
      per_pend_d = per_pend_q;
      mpb_bit_d  = mpb_bit_q;
      rdr_d      = rdr_q;
      rdrf_d     = rdrf_q;
      orer_d     = orer_q;
      fer_d      = fer_q;
      per_d      = per_q;
      mpb_d      = mpb_q;
      mpie_clr_d = mpie_clr_q;

      if (CE) begin
         sync_d     = SYNC_STAGES'({sync_q, RXD});
         rxd_prev_d = rxd_s;
         mpie_clr_d = 1'b0;

         // Clears are applied first so a commit later in this block wins.
         if (RDRF_CLR) rdrf_d = 1'b0;
         if (ORER_CLR) orer_d = 1'b0;
         if (FER_CLR)  fer_d  = 1'b0;
         if (PER_CLR)  per_d  = 1'b0;

         if (BAUD_TICK) cnt_d = cnt_q + 4'd1;

         if (!RE) begin
            state_d   = S_IDLE;
            cnt_d     = 4'd0;
            bit_idx_d = 3'd0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  cnt_d     = 4'd0;
                  bit_idx_d = 3'd0;
                  if (rxd_prev_q && !rxd_s && !err_block) state_d = S_START;
               end
               S_START: begin
                  if (sample) begin
                     per_pend_d = 1'b0;
                     mpb_bit_d  = 1'b0;
                     state_d    = rxd_s ? S_IDLE : S_DATA;
                  end
               end
               S_DATA: begin
                  if (sample) begin
                     shreg_d   = {rxd_s, shreg_q[7:1]};
                     bit_idx_d = bit_idx_q + 3'd1;
                     if (bit_idx_q == (chr ? 3'd6 : 3'd7))
                        state_d = (pe || mp) ? S_PARB : S_STOP;
                  end
               end
               S_PARB: begin
                  if (sample) begin
                     if (mp) mpb_bit_d = rxd_s;
                     else    per_pend_d = ((^data_w) ^ rxd_s) != oe;
                     state_d = S_STOP;
                  end
               end
               S_STOP: begin
                  if (sample) begin
                     state_d = S_IDLE;
                     if (rdrf_q) begin
                        orer_d = 1'b1;
                     end else if (!(mp && MPIE && !mpb_bit_q)) begin
                        rdr_d  = data_w;
                        rdrf_d = 1'b1;
                        if (!rxd_s)     fer_d = 1'b1;
                        if (per_pend_q) per_d = 1'b1;
                        mpb_d      = mp & mpb_bit_q;
                        mpie_clr_d = mp & MPIE & mpb_bit_q;
                     end
                  end
               end
               default: state_d = S_IDLE;
            endcase
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values computed above regardless of statement order.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= S_IDLE;
         sync_q     <= '1;
         rxd_prev_q <= 1'b1;
         cnt_q      <= 4'd0;
         bit_idx_q  <= 3'd0;
         shreg_q    <= 8'h00;
         per_pend_q <= 1'b0;
         mpb_bit_q  <= 1'b0;
         rdr_q      <= 8'h00;
         rdrf_q     <= 1'b0;
         orer_q     <= 1'b0;
         fer_q      <= 1'b0;
         per_q      <= 1'b0;
         mpb_q      <= 1'b0;
         mpie_clr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         rxd_prev_q <= rxd_prev_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         shreg_q    <= shreg_d;
         per_pend_q <= per_pend_d;
         mpb_bit_q  <= mpb_bit_d;
         rdr_q      <= rdr_d;
         rdrf_q     <= rdrf_d;
         orer_q     <= orer_d;
         fer_q      <= fer_d;
         per_q      <= per_d;
         mpb_q      <= mpb_d;
         mpie_clr_q <= mpie_clr_d;
      end
   end

   assign RDR      = rdr_q;
   assign RDRF     = rdrf_q;
   assign ORER     = orer_q;
   assign FER      = fer_q;
   assign PER      = per_q;
   assign MPB      = mpb_q;
   assign MPIE_CLR = mpie_clr_q;

endmodule

// File: tb/tb_sh7604_sci_rx.sv
// Directed bench for sh7604_sci_rx: one task per scenario, hand-computed
// expected RDR and status {RDRF,ORER,FER,PER,MPB} after each frame.
module tb_sh7604_sci_rx;

   localparam int BIT = 64;  // 16 ticks x 4 clocks per tick

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       CE = 1'b1;
   logic       BAUD_TICK = 1'b0;
   logic       RXD = 1'b1;
   logic [7:0] SMR = 8'h00;
   logic       RE = 1'b0;
   logic       MPIE = 1'b0;
   logic       RDRF_CLR = 1'b0;
   logic       ORER_CLR = 1'b0;
   logic       FER_CLR = 1'b0;
   logic       PER_CLR = 1'b0;
   logic [7:0] RDR;
   logic       RDRF, ORER, FER, PER, MPB, MPIE_CLR;

   int asserts = 0;
   int fails = 0;
   int mpie_clr_cnt = 0;
   int tick_div = 0;

   sh7604_sci_rx #(.SYNC_STAGES(2)) dut (
      .CLK(CLK), .RST_N(RST_N), .CE(CE), .BAUD_TICK(BAUD_TICK), .RXD(RXD),
      .SMR(SMR), .RE(RE), .MPIE(MPIE),
      .RDRF_CLR(RDRF_CLR), .ORER_CLR(ORER_CLR), .FER_CLR(FER_CLR), .PER_CLR(PER_CLR),
      .RDR(RDR), .RDRF(RDRF), .ORER(ORER), .FER(FER), .PER(PER), .MPB(MPB),
      .MPIE_CLR(MPIE_CLR)
   );

   always #5 CLK = ~CLK;

   initial forever begin
      @(negedge CLK);
      tick_div  = tick_div + 1;
      BAUD_TICK = (tick_div % 4 == 0);
   end

   initial forever begin
      @(negedge CLK);
      if (MPIE_CLR === 1'b1) mpie_clr_cnt = mpie_clr_cnt + 1;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic send_frame(input logic [7:0] data, input int nbits, input bit has_par,
                             input logic par, input logic stop_b);
      @(negedge CLK);
      RXD = 1'b0;
      repeat (BIT) @(negedge CLK);
      for (int i = 0; i < nbits; i++) begin
         RXD = data[i];
         repeat (BIT) @(negedge CLK);
      end
      if (has_par) begin
         RXD = par;
         repeat (BIT) @(negedge CLK);
      end
      RXD = stop_b;
      repeat (BIT) @(negedge CLK);
      RXD = 1'b1;
      repeat (BIT / 2) @(negedge CLK);
   endtask

   task automatic clr(input logic r, input logic o, input logic f, input logic p);
      @(negedge CLK);
      RDRF_CLR = r; ORER_CLR = o; FER_CLR = f; PER_CLR = p;
      @(negedge CLK);
      RDRF_CLR = 1'b0; ORER_CLR = 1'b0; FER_CLR = 1'b0; PER_CLR = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_reset;
      RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      asserts++;
      if (RDR !== 8'h00) begin $display("FAIL reset_rdr: got %h want 00", RDR); fails++; end
      asserts++;
      if ({RDRF, ORER, FER, PER, MPB, MPIE_CLR} !== 6'b0) begin
         $display("FAIL reset_flags: got %b want 000000", {RDRF, ORER, FER, PER, MPB, MPIE_CLR}); fails++;
      end
      RST_N = 1'b1;
      RE    = 1'b1;
      repeat (4) @(negedge CLK);
      asserts++;
      if ({RDRF, ORER, FER, PER, MPB} !== 5'b0) begin
         $display("FAIL post_reset_flags: got %b want 00000", {RDRF, ORER, FER, PER, MPB}); fails++;
      end
   endtask

   task automatic test_8n1;
      int lat = 0;
      SMR = 8'h00;
      fork
         send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
         begin
            while (RDRF !== 1'b1 && lat < 1000) begin
               @(negedge CLK);
               lat++;
            end
         end
      join
      asserts++;
      if (lat < 604 || lat > 616) begin
         $display("FAIL 8n1_latency: got %0d cycles want 604..616", lat); fails++;
      end
      asserts++;
      if (RDR !== 8'hA5) begin $display("FAIL 8n1_rdr: got %h want a5", RDR); fails++; end
      asserts++;
      if ({RDRF, ORER, FER, PER, MPB} !== 5'b10000) begin
         $display("FAIL 8n1_flags: got %b want 10000", {RDRF, ORER, FER, PER, MPB}); fails++;
      end
      clr(1'b1, 1'b0, 1'b0, 1'b0);
      asserts++;
      if (RDRF !== 1'b0) begin $display("FAIL 8n1_rdrf_clr: got %b want 0", RDRF); fails++; end
   endtask

   task automatic test_parity;
      SMR = 8'h60;  // 7 bits, even parity
      send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
      asserts++;
      if (RDR !== 8'h41) begin $display("FAIL par_rdr: got %h want 41", RDR); fails++; end
      asserts++;
      if ({RDRF, ORER, FER, PER, MPB} !== 5'b10010) begin
         $display("FAIL par_flags: got %b want 10010", {RDRF, ORER, FER, PER, MPB}); fails++;
      end
      send_frame(8'h22, 7, 1'b1, 1'b0, 1'b1);
      asserts++;
      if (RDR !== 8'h41 || {RDRF, ORER, FER, PER, MPB} !== 5'b10010) begin
         $display("FAIL par_blocked: got rdr %h flags %b want 41 10010", RDR, {RDRF, ORER, FER, PER, MPB}); fails++;
      end
      clr(1'b1, 1'b0, 1'b0, 1'b1);
      send_frame(8'h22, 7, 1'b1, 1'b0, 1'b1);
      asserts++;
      if (RDR !== 8'h22 || {RDRF, ORER, FER, PER, MPB} !== 5'b10000) begin
         $display("FAIL par_even_ok: got rdr %h flags %b want 22 10000", RDR, {RDRF, ORER, FER, PER, MPB}); fails++;
      end
      clr(1'b1, 1'b0, 1'b0, 1'b0);
      SMR = 8'h70;  // 7 bits, odd parity
      send_frame(8'h23, 7, 1'b1, 1'b0, 1'b1);
      asserts++;
      if (RDR !== 8'h23 || {RDRF, ORER, FER, PER, MPB} !== 5'b10000) begin
         $display("FAIL par_odd_ok: got rdr %h flags %b want 23 10000", RDR, {RDRF, ORER, FER, PER, MPB}); fails++;
      end
      clr(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_overrun;
      SMR = 8'h00;
      send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
      asserts++;
      if (RDR !== 8'h5A || RDRF !== 1'b1) begin
         $display("FAIL ovr_first: got rdr %h rdrf %b want 5a 1", RDR, RDRF); fails++;
      end
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
      asserts++;
      if (RDR !== 8'h5A) begin $display("FAIL ovr_rdr_held: got %h want 5a", RDR); fails++; end
      asserts++;
      if ({RDRF, ORER, FER, PER, MPB} !== 5'b11000) begin
         $display("FAIL ovr_flags: got %b want 11000", {RDRF, ORER, FER, PER, MPB}); fails++;
      end
      clr(1'b1, 1'b1, 1'b0, 1'b0);
      asserts++;
      if ({RDRF, ORER} !== 2'b00) begin $display("FAIL ovr_clr: got %b want 00", {RDRF, ORER}); fails++; end
   endtask

   task automatic test_mp;
      SMR  = 8'h04;
      MPIE = 1'b1;
      mpie_clr_cnt = 0;
      send_frame(8'h12, 8, 1'b1, 1'b0, 1'b1);
      asserts++;
      if (RDR !== 8'h5A || {RDRF, ORER, FER, PER, MPB} !== 5'b00000 || mpie_clr_cnt != 0) begin
         $display("FAIL mp_discard: got rdr %h flags %b pulses %0d want 5a 00000 0",
                  RDR, {RDRF, ORER, FER, PER, MPB}, mpie_clr_cnt); fails++;
      end
      send_frame(8'h34, 8, 1'b1, 1'b1, 1'b1);
      asserts++;
      if (RDR !== 8'h34 || {RDRF, ORER, FER, PER, MPB} !== 5'b10001) begin
         $display("FAIL mp_accept: got rdr %h flags %b want 34 10001", RDR, {RDRF, ORER, FER, PER, MPB}); fails++;
      end
      asserts++;
      if (mpie_clr_cnt != 1) begin $display("FAIL mp_mpie_clr: got %0d pulses want 1", mpie_clr_cnt); fails++; end
      MPIE = 1'b0;
      SMR  = 8'h00;
      clr(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_glitch_framing;
      @(negedge CLK);
      RXD = 1'b0;
      repeat (16) @(negedge CLK);
      RXD = 1'b1;
      repeat (2 * BIT) @(negedge CLK);
      asserts++;
      if (RDR !== 8'h34 || {RDRF, ORER, FER, PER, MPB} !== 5'b00001) begin
         $display("FAIL glitch: got rdr %h flags %b want 34 00001", RDR, {RDRF, ORER, FER, PER, MPB}); fails++;
      end
      send_frame(8'h96, 8, 1'b0, 1'b0, 1'b0);
      asserts++;
      if (RDR !== 8'h96 || {RDRF, ORER, FER, PER, MPB} !== 5'b10100) begin
         $display("FAIL framing: got rdr %h flags %b want 96 10100", RDR, {RDRF, ORER, FER, PER, MPB}); fails++;
      end
      clr(1'b1, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_abort;
      int n = 0;
      send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
      fork
         send_frame(8'h77, 8, 1'b0, 1'b0, 1'b1);
         begin
            repeat (4 * BIT + BIT / 2) @(negedge CLK);
            RE = 1'b0;
         end
      join
      RE = 1'b1;
      repeat (4) @(negedge CLK);
      asserts++;
      if (RDR !== 8'h11 || {RDRF, ORER, FER, PER, MPB} !== 5'b10000) begin
         $display("FAIL abort_held: got rdr %h flags %b want 11 10000", RDR, {RDRF, ORER, FER, PER, MPB}); fails++;
      end
      clr(1'b1, 1'b0, 1'b0, 1'b0);
      fork
         send_frame(8'h5C, 8, 1'b0, 1'b0, 1'b1);
         begin
            repeat (9 * BIT) @(negedge CLK);
            RDRF_CLR = 1'b1;
            while (RDRF !== 1'b1 && n < 2 * BIT) begin
               @(negedge CLK);
               n++;
            end
            RDRF_CLR = 1'b0;
         end
      join
      asserts++;
      if (n >= 2 * BIT) begin $display("FAIL set_vs_clr_timeout: waited %0d cycles want < %0d", n, 2 * BIT); fails++; end
      asserts++;
      if (RDR !== 8'h5C || RDRF !== 1'b1) begin
         $display("FAIL set_vs_clr: got rdr %h rdrf %b want 5c 1", RDR, RDRF); fails++;
      end
      clr(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_midframe;
      @(negedge CLK);
      RXD = 1'b0;
      repeat (BIT) @(negedge CLK);
      RXD = 1'b1;
      repeat (BIT) @(negedge CLK);
      RXD = 1'b0;
      repeat (BIT / 2) @(negedge CLK);
      RST_N = 1'b0;
      repeat (4) @(negedge CLK);
      RXD   = 1'b1;
      RST_N = 1'b1;
      repeat (12 * BIT) @(negedge CLK);
      asserts++;
      if (RDR !== 8'h00 || {RDRF, ORER, FER, PER, MPB} !== 5'b00000) begin
         $display("FAIL reset_midframe: got rdr %h flags %b want 00 00000", RDR, {RDRF, ORER, FER, PER, MPB}); fails++;
      end
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_overrun();
      test_mp();
      test_glitch_framing();
      test_abort();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
